idma_2d_rep_midend: RTL and testbench
=====================================

Name: idma_2d_rep_midend

Overview:
- Downstream neighbour of the 2D register frontend.
- Accepts one 2D transfer (base burst + repetitions + src/dst strides) per handshake.
- Unrolls it into `reps` 1D burst requests for the iDMA backend, advancing addresses by the strides.
- Tracks backend completions per 2D job and pulses a job-done strobe, which feeds the frontend's transfer-complete/ID retire input.

Parameters:
- AddrWidth, 64, width of src/dst addresses and strides.
- LenWidth, 64, width of burst length.
- RepWidth, 64, width of repetition count.
- OptWidth, 64, width of opaque burst option bits, passed through unchanged.
- NumOutstanding, 4, maximum accepted-but-not-completed 2D jobs (power of two, ≥2).

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- nd_valid_i  in  1  2D job valid
- nd_ready_o  out  1  2D job accepted when valid&ready
- nd_src_addr_i  in  AddrWidth  base source address
- nd_dst_addr_i  in  AddrWidth  base destination address
- nd_length_i  in  LenWidth  bytes per repetition
- nd_opt_i  in  OptWidth  burst options
- nd_reps_i  in  RepWidth  repetition count
- nd_src_stride_i  in  AddrWidth  source stride (two's complement)
- nd_dst_stride_i  in  AddrWidth  destination stride (two's complement)
- burst_valid_o  out  1  1D burst valid
- burst_ready_i  in  1  backend accepts burst
- burst_src_addr_o  out  AddrWidth  burst source address
- burst_dst_addr_o  out  AddrWidth  burst destination address
- burst_length_o  out  LenWidth  burst length
- burst_opt_o  out  OptWidth  burst options
- burst_done_i  in  1  backend retired one burst (in order)
- nd_done_o  out  1  one-cycle pulse: oldest 2D job fully retired
- busy_o  out  1  job issuing or completions outstanding

Behaviour:
- Clock and reset: single clock clk_i; reset rst_ni is asynchronous, active-low.
- Reset values: all outputs 0 except nd_ready_o=1. State IDLE; counters and completion FIFO cleared.
- Reset mid-operation drops all jobs; no nd_done_o for them.
- State IDLE:
  - nd_ready_o = 1 iff the completion FIFO is not full.
  - On handshake: latch all nd_* fields into job regs; set rep counter = (nd_reps_i==0 ? 1 : nd_reps_i); push the same count into the completion FIFO; go to ISSUE.
  - nd_ready_o is 0 in ISSUE.
- State ISSUE:
  - burst_valid_o = 1. Outputs are driven from registers (job regs / current address regs).
  - Outputs are stable while valid && !ready.
  - On burst_ready_i:
    - current src += src_stride, dst += dst_stride (modulo 2^AddrWidth wrap, no saturation);
    - rep counter decrements;
    - if counter was 1, go to IDLE.
  - First burst appears the cycle after nd handshake (latency 1). Back-to-back bursts are possible every cycle.
  - No bubble requirement between jobs: one idle cycle in IDLE is permitted.
- Completion:
  - Head counter counts burst_done_i.
  - When the count reaches the FIFO head value, that cycle's registered output pulses nd_done_o=1 for exactly 1 cycle (next cycle after the final burst_done_i); pop the head; reset the counter.
  - burst_done_i in the same cycle as a FIFO push is legal.
  - A push into an empty FIFO with simultaneous pop is not possible (pop requires a prior entry).
  - burst_done_i with no outstanding entry is a protocol violation: ignored, flagged by a simulation assertion.
- busy_o = (state==ISSUE) | FIFO non-empty.
- Widths:
  - Stride add is AddrWidth-bit unsigned add (negative strides via two's complement).
  - FIFO entries are RepWidth bits.

Optional Feature:
- Macro: IDMA_2D_ZERO_LEN_SKIP_EN.
- Defined:
  - A job with nd_length_i==0 is accepted but issues no bursts (stays in IDLE).
  - It pushes count 0; when that entry reaches the FIFO head, nd_done_o pulses the following cycle without any burst_done_i.
  - Ordering with earlier jobs is preserved.
- Undefined: zero-length jobs are unrolled like any other (reps bursts of length 0 forwarded to the backend).

Test Plan:
- Basic unroll: src=0x1000, dst=0x8000, len=64, reps=3, strides 0x100/0x40, ready always 1 -> bursts (0x1000,0x8000), (0x1100,0x8040), (0x1200,0x8080) on 3 consecutive cycles; after 3 burst_done_i, nd_done_o pulses once.
- Backpressure: burst_ready_i low for 5 cycles on the second burst -> outputs held stable at (0x1100,0x8040); no address advance.
- reps=0 and negative stride: reps=0 -> exactly 1 burst; src=0x10, stride=-0x10, reps=2 -> addresses 0x10 then 0x0.
- Outstanding limit: NumOutstanding=4, 4 single-rep jobs with no burst_done_i -> nd_ready_o=0 on the 5th; one burst_done_i -> nd_done_o pulse, then nd_ready_o=1.
- Async reset during ISSUE at rep 2 of 4 -> outputs reset immediately; no nd_done_o afterwards; busy_o=0.
- With IDMA_2D_ZERO_LEN_SKIP_EN: len=0, reps=5 queued behind a reps=2 job -> no bursts for it; nd_done_o pulses for job1 then job2 on consecutive cycles after job1's 2 done. Without the macro -> 5 zero-length bursts issued.

Source files
------------

// File: rtl/idma_2d_rep_midend.sv
// 2D midend: unrolls one 2D job into reps 1D bursts and retires jobs from in-order completions.
// Optional IDMA_2D_ZERO_LEN_SKIP_EN: zero-length jobs issue no bursts and retire without completions.
module idma_2d_rep_midend #(
    parameter int unsigned AddrWidth      = 64,
    parameter int unsigned LenWidth       = 64,
    parameter int unsigned RepWidth       = 64,
    parameter int unsigned OptWidth       = 64,
    parameter int unsigned NumOutstanding = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 nd_valid_i,
    output logic                 nd_ready_o,
    input  logic [AddrWidth-1:0] nd_src_addr_i,
    input  logic [AddrWidth-1:0] nd_dst_addr_i,
    input  logic [LenWidth-1:0]  nd_length_i,
    input  logic [OptWidth-1:0]  nd_opt_i,
    input  logic [RepWidth-1:0]  nd_reps_i,
    input  logic [AddrWidth-1:0] nd_src_stride_i,
    input  logic [AddrWidth-1:0] nd_dst_stride_i,
    output logic                 burst_valid_o,
    input  logic                 burst_ready_i,
    output logic [AddrWidth-1:0] burst_src_addr_o,
    output logic [AddrWidth-1:0] burst_dst_addr_o,
    output logic [LenWidth-1:0]  burst_length_o,
    output logic [OptWidth-1:0]  burst_opt_o,
    input  logic                 burst_done_i,
    output logic                 nd_done_o,
    output logic                 busy_o
);
    localparam int unsigned PtrWidth = $clog2(NumOutstanding);

    typedef enum logic [0:0] {StIdle, StIssue} state_e;

    state_e state_q, state_d;

    logic [AddrWidth-1:0] src_q, src_d, dst_q, dst_d;
    logic [AddrWidth-1:0] src_stride_q, dst_stride_q;
    logic [LenWidth-1:0]  length_q;
    logic [OptWidth-1:0]  opt_q;
    logic [RepWidth-1:0]  rep_cnt_q, rep_cnt_d;

    logic [RepWidth-1:0]  fifo_mem_q [NumOutstanding];
    logic [PtrWidth-1:0]  wr_ptr_q, rd_ptr_q;
    logic [PtrWidth:0]    fifo_cnt_q;
    logic                 fifo_full, fifo_empty, push, pop;
    logic [RepWidth-1:0]  reps_eff, push_cnt, head_cnt;
    logic [RepWidth:0]    done_eff;
    logic [RepWidth-1:0]  done_cnt_q, done_cnt_d;
    logic                 nd_done_q;
    logic                 accept, skip_job;

    assign fifo_full  = (fifo_cnt_q == (PtrWidth+1)'(NumOutstanding));
    assign fifo_empty = (fifo_cnt_q == '0);
    assign head_cnt   = fifo_mem_q[rd_ptr_q];

    always_comb begin
        reps_eff = (nd_reps_i == '0) ? RepWidth'(1) : nd_reps_i;
`ifdef IDMA_2D_ZERO_LEN_SKIP_EN
        skip_job = (nd_length_i == '0);
`else
        skip_job = 1'b0;
`endif
        push_cnt = skip_job ? '0 : reps_eff;
    end

    always_comb begin
        state_d       = state_q;
        src_d         = src_q;
        dst_d         = dst_q;
        rep_cnt_d     = rep_cnt_q;
        nd_ready_o    = 1'b0;
        burst_valid_o = 1'b0;
        accept        = 1'b0;
        unique case (state_q)
            StIdle: begin
                nd_ready_o = !fifo_full;
                accept     = nd_valid_i && !fifo_full;
                if (accept) begin
                    src_d     = nd_src_addr_i;
                    dst_d     = nd_dst_addr_i;
                    rep_cnt_d = reps_eff;
                    if (!skip_job) state_d = StIssue;
                end
            end
            StIssue: begin
                burst_valid_o = 1'b1;
                if (burst_ready_i) begin
                    src_d     = src_q + src_stride_q;
                    dst_d     = dst_q + dst_stride_q;
                    rep_cnt_d = rep_cnt_q - 1'b1;
                    if (rep_cnt_q == RepWidth'(1)) state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Completions beyond the head's count carry over to the next job (only possible
    // when zero-count heads are being retired).
    always_comb begin
        push       = accept;
        done_eff   = {1'b0, done_cnt_q} + (RepWidth+1)'(burst_done_i && !fifo_empty);
        pop        = !fifo_empty && (done_eff >= {1'b0, head_cnt});
        done_cnt_d = done_cnt_q;
        if (pop) begin
            done_cnt_d = RepWidth'(done_eff - {1'b0, head_cnt});
        end else if (!fifo_empty) begin
            done_cnt_d = done_eff[RepWidth-1:0];
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= StIdle;
            src_q        <= '0;
            dst_q        <= '0;
            src_stride_q <= '0;
            dst_stride_q <= '0;
            length_q     <= '0;
            opt_q        <= '0;
            rep_cnt_q    <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            fifo_cnt_q   <= '0;
            done_cnt_q   <= '0;
            nd_done_q    <= 1'b0;
            for (int i = 0; i < NumOutstanding; i++) fifo_mem_q[i] <= '0;
        end else begin
            state_q    <= state_d;
            src_q      <= src_d;
            dst_q      <= dst_d;
            rep_cnt_q  <= rep_cnt_d;
            done_cnt_q <= done_cnt_d;
            nd_done_q  <= pop;
            if (accept) begin
                src_stride_q <= nd_src_stride_i;
                dst_stride_q <= nd_dst_stride_i;
                length_q     <= nd_length_i;
                opt_q        <= nd_opt_i;
            end
            if (push) begin
                fifo_mem_q[wr_ptr_q] <= push_cnt;
                wr_ptr_q             <= wr_ptr_q + 1'b1;
            end
            if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({push, pop})
                2'b10:   fifo_cnt_q <= fifo_cnt_q + 1'b1;
                2'b01:   fifo_cnt_q <= fifo_cnt_q - 1'b1;
                default: fifo_cnt_q <= fifo_cnt_q;
            endcase
        end
    end

    assign burst_src_addr_o = src_q;
    assign burst_dst_addr_o = dst_q;
    assign burst_length_o   = length_q;
    assign burst_opt_o      = opt_q;
    assign nd_done_o        = nd_done_q;
    assign busy_o           = (state_q == StIssue) || !fifo_empty;

`ifndef SYNTHESIS
    always_ff @(posedge clk_i) begin
        if (rst_ni) begin
            assert (!(burst_done_i && fifo_empty))
            else $error("burst_done_i received with no outstanding 2D job");
        end
    end
`endif

endmodule

// File: tb/tb_idma_2d_rep_midend.sv
// Randomized bench for idma_2d_rep_midend against a queue-based model of expected bursts
// and cumulative completion thresholds per job.
module tb_idma_2d_rep_midend;
`ifdef IDMA_2D_ZERO_LEN_SKIP_EN
    localparam bit ZeroSkip = 1'b1;
`else
    localparam bit ZeroSkip = 1'b0;
`endif
    localparam int NumOut = 4;

    typedef struct packed {
        logic [63:0] src, dst, len, opt;
    } burst_t;

    typedef struct packed {
        logic [63:0] src, dst, len, opt, reps, sstr, dstr;
    } job_t;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        nd_valid_i = 1'b0;
    logic        nd_ready_o;
    logic [63:0] nd_src_addr_i = '0, nd_dst_addr_i = '0, nd_length_i = '0, nd_opt_i = '0;
    logic [63:0] nd_reps_i = '0, nd_src_stride_i = '0, nd_dst_stride_i = '0;
    logic        burst_valid_o;
    logic        burst_ready_i = 1'b0;
    logic [63:0] burst_src_addr_o, burst_dst_addr_o, burst_length_o, burst_opt_o;
    logic        burst_done_i = 1'b0;
    logic        nd_done_o;
    logic        busy_o;

    idma_2d_rep_midend dut (
        .clk_i            (clk_i),
        .rst_ni           (rst_ni),
        .nd_valid_i       (nd_valid_i),
        .nd_ready_o       (nd_ready_o),
        .nd_src_addr_i    (nd_src_addr_i),
        .nd_dst_addr_i    (nd_dst_addr_i),
        .nd_length_i      (nd_length_i),
        .nd_opt_i         (nd_opt_i),
        .nd_reps_i        (nd_reps_i),
        .nd_src_stride_i  (nd_src_stride_i),
        .nd_dst_stride_i  (nd_dst_stride_i),
        .burst_valid_o    (burst_valid_o),
        .burst_ready_i    (burst_ready_i),
        .burst_src_addr_o (burst_src_addr_o),
        .burst_dst_addr_o (burst_dst_addr_o),
        .burst_length_o   (burst_length_o),
        .burst_opt_o      (burst_opt_o),
        .burst_done_i     (burst_done_i),
        .nd_done_o        (nd_done_o),
        .busy_o           (busy_o)
    );

    always #5 clk_i = ~clk_i;

    int tests = 0;
    int fails = 0;

    // Model state
    job_t            pend_jobs[$];
    burst_t          exp_b[$];
    longint unsigned job_thr[$];
    longint unsigned total_done = 0;
    longint unsigned thr_tail = 0;
    bit              exp_done_next = 1'b0;
    int              pend_done = 0;
    int              issued = 0;
    int              stall_idx = -1;
    int              stall_left = 0;
    int              rdy_pct = 100;
    int              done_pct = 100;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_accept(input job_t j);
        longint unsigned n;
        burst_t b;
        n = (j.reps == 0) ? 1 : j.reps;
        if (ZeroSkip && j.len == 0) n = 0;
        for (longint unsigned k = 0; k < n; k++) begin
            b.src = j.src + 64'(k) * j.sstr;
            b.dst = j.dst + 64'(k) * j.dstr;
            b.len = j.len;
            b.opt = j.opt;
            exp_b.push_back(b);
        end
        thr_tail += n;
        job_thr.push_back(thr_tail);
    endtask

    task automatic check_update();
        bit m_ready;
        m_ready = (exp_b.size() == 0) && (job_thr.size() < NumOut);
        chk("nd_ready", nd_ready_o, m_ready);
        chk("burst_valid", burst_valid_o, exp_b.size() != 0);
        chk("busy", busy_o, (exp_b.size() != 0) || (job_thr.size() != 0));
        chk("nd_done", nd_done_o, exp_done_next);
        if (exp_b.size() != 0) begin
            chk("burst_src", burst_src_addr_o, exp_b[0].src);
            chk("burst_dst", burst_dst_addr_o, exp_b[0].dst);
            chk("burst_len", burst_length_o, exp_b[0].len);
            chk("burst_opt", burst_opt_o, exp_b[0].opt);
        end
        exp_done_next = 1'b0;
        if (exp_b.size() != 0 && burst_ready_i) begin
            void'(exp_b.pop_front());
            pend_done++;
            issued++;
        end
        if (burst_done_i) begin
            total_done++;
            pend_done--;
        end
        if (job_thr.size() != 0 && total_done >= job_thr[0]) begin
            void'(job_thr.pop_front());
            exp_done_next = 1'b1;
        end
        if (nd_valid_i && m_ready) model_accept(pend_jobs.pop_front());
    endtask

    // Called at posedge+1: drive inputs, check at negedge, return at next posedge+1.
    task automatic cycle();
        job_t j;
        if (pend_jobs.size() != 0) begin
            j               = pend_jobs[0];
            nd_valid_i      = 1'b1;
            nd_src_addr_i   = j.src;
            nd_dst_addr_i   = j.dst;
            nd_length_i     = j.len;
            nd_opt_i        = j.opt;
            nd_reps_i       = j.reps;
            nd_src_stride_i = j.sstr;
            nd_dst_stride_i = j.dstr;
        end else begin
            nd_valid_i = 1'b0;
        end
        if (exp_b.size() != 0 && issued == stall_idx && stall_left > 0) begin
            burst_ready_i = 1'b0;
            stall_left--;
        end else begin
            burst_ready_i = ($urandom_range(99) < rdy_pct);
        end
        burst_done_i = (pend_done > 0) && ($urandom_range(99) < done_pct);
        @(negedge clk_i);
        check_update();
        @(posedge clk_i);
        #1;
    endtask

    task automatic add_job(input logic [63:0] src, input logic [63:0] dst, input logic [63:0] len,
                           input logic [63:0] reps, input logic [63:0] sstr,
                           input logic [63:0] dstr);
        job_t j;
        j.src  = src;
        j.dst  = dst;
        j.len  = len;
        j.opt  = {$urandom, $urandom};
        j.reps = reps;
        j.sstr = sstr;
        j.dstr = dstr;
        pend_jobs.push_back(j);
    endtask

    task automatic drain();
        int n = 0;
        while ((pend_jobs.size() != 0 || exp_b.size() != 0 || job_thr.size() != 0 ||
                pend_done != 0 || exp_done_next) && n < 3000) begin
            cycle();
            n++;
        end
        chk("drain_timeout", n < 3000, 1'b1);
        cycle();
        cycle();
    endtask

    initial begin
        int n;
        #1;
        chk("rst_nd_ready", nd_ready_o, 1'b1);
        chk("rst_burst_valid", burst_valid_o, 1'b0);
        chk("rst_nd_done", nd_done_o, 1'b0);
        chk("rst_busy", busy_o, 1'b0);
        chk("rst_src", burst_src_addr_o, 64'h0);
        #11 rst_ni = 1'b1;
        @(posedge clk_i);
        #1;

        // Basic unroll
        add_job(64'h1000, 64'h8000, 64'd64, 64'd3, 64'h100, 64'h40);
        drain();

        // Backpressure on the second burst
        stall_idx  = issued + 1;
        stall_left = 5;
        add_job(64'h1000, 64'h8000, 64'd64, 64'd3, 64'h100, 64'h40);
        drain();
        chk("stall_consumed", stall_left, 0);

        // reps=0 and negative stride
        add_job(64'h2000, 64'h3000, 64'd16, 64'd0, 64'h10, 64'h10);
        add_job(64'h10, 64'h20, 64'd8, 64'd2, -64'sh10, -64'sh10);
        drain();

        // Outstanding limit
        done_pct = 0;
        for (int i = 0; i < 5; i++) add_job(64'h100 * i, 64'h4000, 64'd4, 64'd1, 64'h0, 64'h0);
        for (int i = 0; i < 20; i++) cycle();
        chk("fifth_held", pend_jobs.size(), 1);
        chk("ready_full", nd_ready_o, 1'b0);
        done_pct = 100;
        drain();

        // Zero-length job behind a two-rep job
        add_job(64'h5000, 64'h6000, 64'd32, 64'd2, 64'h20, 64'h20);
        add_job(64'h7000, 64'h9000, 64'd0, 64'd5, 64'h8, 64'h8);
        drain();

        // Randomized mix
        rdy_pct  = 70;
        done_pct = 50;
        for (int i = 0; i < 40; i++) begin
            add_job({$urandom, $urandom}, {$urandom, $urandom},
                    ($urandom_range(3) == 0) ? 64'd0 : 64'($urandom),
                    64'($urandom_range(4)),
                    ($urandom_range(1) == 0) ? {$urandom, $urandom} : -64'($urandom_range(64)),
                    64'($urandom_range(4096)));
        end
        drain();

        // Asynchronous reset during rep 2 of 4
        rdy_pct  = 100;
        done_pct = 0;
        n        = issued + 1;
        add_job(64'hA000, 64'hB000, 64'd64, 64'd4, 64'h100, 64'h100);
        for (int i = 0; i < 20 && issued < n; i++) cycle();
        chk("reached_rep2", issued, n);
        rst_ni = 1'b0;
        #1;
        chk("arst_burst_valid", burst_valid_o, 1'b0);
        chk("arst_src", burst_src_addr_o, 64'h0);
        chk("arst_busy", busy_o, 1'b0);
        chk("arst_nd_ready", nd_ready_o, 1'b1);
        chk("arst_nd_done", nd_done_o, 1'b0);
        pend_jobs.delete();
        exp_b.delete();
        job_thr.delete();
        total_done    = 0;
        thr_tail      = 0;
        exp_done_next = 1'b0;
        pend_done     = 0;
        nd_valid_i    = 1'b0;
        burst_done_i  = 1'b0;
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(posedge clk_i);
        #1;
        for (int i = 0; i < 10; i++) cycle();
        done_pct = 100;
        add_job(64'h40, 64'h80, 64'd1, 64'd2, 64'h4, 64'h4);
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
